// File: rtl/step_pkg.sv
// Shared definitions for the stepper pulse generator and monitor.
// Holds the monitor state encoding and the common timing constants.
package step_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int DEF_SIZE    = 16;
    localparam int CLK_HZ      = 50_000_000;
    localparam int NUM_PERIOD  = 2000;
    localparam int DEF_TIMEOUT = 2 * NUM_PERIOD;

endpackage

// File: rtl/pulse_sync_edge.sv
// Synchronizes the step line, applies polarity and detects edges.
// level_o is the polarity-corrected synchronized level.
module pulse_sync_edge
    import step_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_i,
    input  logic invert_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              s;
    logic              s_d_q;

    assign s = sync_q[STAGES-1] ^ invert_i;

    // synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pulse_i};
            s_d_q  <= s;
        end
    end

    assign level_o = s;
    assign rise_o  = s & ~s_d_q;
    assign fall_o  = ~s & s_d_q;

endmodule

// File: rtl/step_pulse_monitor.sv
// Step pulse receive monitor: counts pulses, measures period/width,
// and flags stall and target-count completion.
module step_pulse_monitor
    import step_pkg::*;
#(
    parameter int SIZE        = DEF_SIZE,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pulse_in,
    input  logic            invert_pulse,
    input  logic            cnt_en,
    input  logic            clr_cnt,
    input  logic [SIZE-1:0] n_target,
    output logic [SIZE-1:0] pulse_cnt,
    output logic [SIZE-1:0] period,
    output logic [SIZE-1:0] width,
    output logic            meas_valid,
    output logic            moving,
    output logic            stall,
    output logic            cnt_done,
    output logic            ovf
);

    localparam logic [SIZE-1:0] ONES = '1;
    localparam logic [SIZE-1:0] ONE  = SIZE'(1);

    logic s;
    logic rise;
    logic fall;
    logic tmo;

    logic [SIZE-1:0] hi_cnt_q, hi_cnt_d;
    logic [SIZE-1:0] per_cnt_q, per_cnt_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    state_e          state_q;
    logic [SIZE-1:0] period_q;
    logic [SIZE-1:0] width_q;
    logic [SIZE-1:0] width_r_q;
    logic            meas_valid_q;
    logic            moving_q;
    logic            stall_q;

    pulse_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .pulse_i  (pulse_in),
        .invert_i (invert_pulse),
        .level_o  (s),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    assign tmo = (32'(per_cnt_q) == 32'(TIMEOUT));

    // saturating high-time and period counters, restarted by each rise
    always_comb begin
        hi_cnt_d  = hi_cnt_q;
        per_cnt_d = per_cnt_q;
        if (rise) begin
            hi_cnt_d  = ONE;
            per_cnt_d = ONE;
        end else begin
            if (s && hi_cnt_q != ONES) begin
                hi_cnt_d = hi_cnt_q + ONE;
            end
            if (per_cnt_q != ONES) begin
                per_cnt_d = per_cnt_q + ONE;
            end
        end
    end

    // pulse count: clear first, then the current edge still counts
    always_comb begin
        cnt_d  = clr_cnt ? '0 : cnt_q;
        ovf_d  = clr_cnt ? 1'b0 : ovf_q;
        done_d = clr_cnt ? 1'b0 : done_q;
        if (rise && cnt_en) begin
            if (cnt_d == ONES) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_d + ONE;
            end
        end
        if (n_target != '0 && cnt_d == n_target) begin
            done_d = 1'b1;
        end
    end

    // counter state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_cnt_q  <= '0;
            per_cnt_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            hi_cnt_q  <= hi_cnt_d;
            per_cnt_q <= per_cnt_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    // motion FSM with registered measurement and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            period_q     <= '0;
            width_q      <= '0;
            width_r_q    <= '0;
            meas_valid_q <= 1'b0;
            moving_q     <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            stall_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q  <= ARM;
                        moving_q <= 1'b1;
                    end
                end
                ARM, RUN: begin
                    if (fall) begin
                        width_r_q <= hi_cnt_q;
                    end
                    if (rise) begin
                        state_q      <= RUN;
                        period_q     <= per_cnt_q;
                        width_q      <= width_r_q;
                        meas_valid_q <= 1'b1;
                    end else if (tmo) begin
                        state_q  <= IDLE;
                        moving_q <= 1'b0;
                        stall_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    moving_q <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_cnt  = cnt_q;
    assign period     = period_q;
    assign width      = width_q;
    assign meas_valid = meas_valid_q;
    assign moving     = moving_q;
    assign stall      = stall_q;
    assign cnt_done   = done_q;
    assign ovf        = ovf_q;

endmodule

// File: doc/step_pulse_monitor.md
Name: step_pulse_monitor

Overview:
- Receive side of the stepper-drive pulse interface: samples the drv_pulse line sent to the SM driver and recovers pulse count, period and high width.
- Flags stall (no pulses) and target-count completion.
- Used as a loopback checker and position counter alongside the pulse generator, in the same 50 MHz domain.

Parameters:
- SIZE, 16, width of all counters and measurement outputs.
- TIMEOUT, 4000, clk cycles without a rising edge before the block declares a stall (2x the 25 kHz period).
- SYNC_STAGES, 2, synchronizer flip-flops on pulse_in (minimum 2).

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  asynchronous, active-low reset.
- pulse_in  in  1  asynchronous step pulse line.
- invert_pulse  in  1  1 = pulse_in is active-low; it is XORed after the synchronizer.
- cnt_en  in  1  enables pulse counting.
- clr_cnt  in  1  one-cycle synchronous clear of pulse_cnt, cnt_done and ovf.
- n_target  in  SIZE  target pulse count; 0 disables cnt_done.
- pulse_cnt  out  SIZE  rising edges counted since the last clear.
- period  out  SIZE  last measured rising-to-rising interval, in clk cycles.
- width  out  SIZE  last measured high time, in clk cycles.
- meas_valid  out  1  one-cycle strobe when period and width update.
- moving  out  1  pulses are arriving (state RUN).
- stall  out  1  one-cycle strobe on the RUN to IDLE timeout.
- cnt_done  out  1  sticky; set when pulse_cnt reaches n_target.
- ovf  out  1  sticky; pulse_cnt saturated.

Behaviour:
- Reset: all outputs, counters and synchronizer flops are 0; state is IDLE.
  - Reset asserted mid-operation discards any partial measurement immediately.
- Input path: SYNC_STAGES flops, then XOR with invert_pulse to give s, then a one-flop s_d for edge detection.
  - rise = s & ~s_d; fall = ~s & s_d.
  - A pin edge is seen as rise/fall SYNC_STAGES+1 cycles later.
  - Toggling invert_pulse can create a spurious edge; this is accepted.
- hi_cnt:
  - Cleared to 1 on rise.
  - Increments while s = 1.
  - Saturates at all-ones.
- per_cnt:
  - Cleared to 1 on rise.
  - Increments every cycle otherwise.
  - Saturates at all-ones.
- FSM, IDLE:
  - On rise, go to ARM; clear per_cnt and hi_cnt.
  - moving = 0.
- FSM, ARM (first period in progress, no valid period yet):
  - moving = 1.
  - On fall, latch width_r <= hi_cnt.
  - On rise, go to RUN: period <= per_cnt, width <= width_r, meas_valid = 1 for one cycle.
  - If per_cnt reaches TIMEOUT, go to IDLE and pulse stall.
- FSM, RUN:
  - Behaves as ARM; every rise updates period and width and strobes meas_valid.
  - If per_cnt reaches TIMEOUT, go to IDLE, moving = 0, stall = 1 for one cycle.
  - period and width hold their last values.
- Pulse counting, on rise with cnt_en = 1 in any state:
  - pulse_cnt increments.
  - At all-ones it holds and sets ovf.
- cnt_done:
  - Set the cycle pulse_cnt becomes equal to n_target (n_target != 0).
  - Stays set even if counting continues.
- clr_cnt and rise in the same cycle: clear takes effect and this edge is counted, so pulse_cnt = 1 (with cnt_en = 1).
- A change of n_target does not clear cnt_done.
- Timeout and rise in the same cycle: rise wins and the state stays RUN.
- Output latency: period, width and meas_valid are registered, one cycle after rise is detected.

Decomposition:
- Shared package step_pkg holds:
  - the state encoding (IDLE, ARM, RUN);
  - the default SIZE;
  - the 50 MHz clock constant;
  - the 25 kHz NUM_PERIOD = 2000, shared with the generator.
- One natural sub-module, pulse_sync_edge: N-flop synchronizer, polarity XOR and rise/fall detect.
- Counters and FSM stay in the top module.

Test Plan:
- 25 kHz train, period 2000 and high 500, five pulses, cnt_en = 1 -> 4 meas_valid strobes; period = 2000, width = 500, pulse_cnt = 5, moving = 1 from the first edge +3 cycles.
- n_target = 100 with 100 pulses then continuing -> cnt_done rises on edge 100 and stays 1; clr_cnt -> pulse_cnt = 0, cnt_done = 0.
- Stop pulses after edge 3 -> stall strobes exactly TIMEOUT cycles after the last detected rise; moving = 0; period/width retain 2000/500.
- invert_pulse = 1 with active-low train (low 500, period 2000) -> width = 500, period = 2000.
- SIZE = 4, 17 pulses -> pulse_cnt holds 15 with ovf = 1; clr_cnt coincident with a rise -> pulse_cnt = 1.
- rst asserted mid-high pulse -> all outputs 0 immediately; next train restarts from IDLE with no spurious meas_valid.
